// File: rtl/dmem_wb_master.sv
// Registered Wishbone master for the memory stage's data port (IDLE -> BUS -> RESP).
// Define DMEM_TIMEOUT_EN to add an ack watchdog that aborts the cycle and sets a sticky dmem_err.
module dmem_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_action_cyc,
    input  logic        dmem_action_stb,
    input  logic        dmem_write,
    input  logic [1:0]  dmem_byte_enable,
    input  logic [15:0] dmem_address,
    input  logic [15:0] dmem_wdata,
    input  logic        load_ex_mem,
    output logic        dmem_resp,
    output logic [15:0] dmem_rdata,
    output logic [1:0]  mem_ack_counter,
    output logic        dmem_err,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [1:0]  wb_sel_o,
    output logic [14:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i
);
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [1:0]  sel_q, sel_d;
    logic [14:0] adr_q, adr_d;
    logic [15:0] dat_q, dat_d;
    logic        resp_q, resp_d;
    logic [15:0] rdata_q, rdata_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        req;
    logic        timeout_hit;

    assign req = dmem_action_cyc & dmem_action_stb;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_q, wait_d;
    logic       err_q, err_d;

    assign timeout_hit = (state_q == S_BUS) && !wb_ack_i && (wait_q == WAIT_LAST);

    always_comb begin
        wait_d = '0;
        err_d  = err_q;
        if (state_q == S_BUS) begin
            wait_d = wait_q + 8'd1;
            if (timeout_hit) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign dmem_err = err_q;
`else
    assign timeout_hit = 1'b0;
    // The watchdog limit has no meaning without the timeout logic.
    assign dmem_err    = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        unique case (state_q)
            S_IDLE:  state_d = req ? S_BUS : S_IDLE;
            S_BUS:   state_d = (wb_ack_i || timeout_hit) ? S_RESP : S_BUS;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus registers fall back to zero whenever no cycle is in flight.
    always_comb begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
        sel_d   = '0;
        adr_d   = '0;
        dat_d   = '0;
        resp_d  = 1'b0;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = dmem_write;
                    sel_d = dmem_write ? dmem_byte_enable : 2'b11;
                    adr_d = dmem_address[15:1];
                    if (dmem_write) begin
                        dat_d = (dmem_byte_enable == 2'b11) ? dmem_wdata
                                                            : {dmem_wdata[7:0], dmem_wdata[7:0]};
                    end
                end
            end
            S_BUS: begin
                if (wb_ack_i) begin
                    resp_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = wb_dat_i;
                    end
                end else if (timeout_hit) begin
                    resp_d  = 1'b1;
                    rdata_d = '0;
                end else begin
                    cyc_d = cyc_q;
                    stb_d = stb_q;
                    we_d  = we_q;
                    sel_d = sel_q;
                    adr_d = adr_q;
                    dat_d = dat_q;
                end
            end
            S_RESP: cnt_d = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
            default: ;
        endcase
        // A new instruction restarts the count even if an access completes now.
        if (load_ex_mem) begin
            cnt_d = '0;
        end
    end

    assign wb_cyc_o        = cyc_q;
    assign wb_stb_o        = stb_q;
    assign wb_we_o         = we_q;
    assign wb_sel_o        = sel_q;
    assign wb_adr_o        = adr_q;
    assign wb_dat_o        = dat_q;
    assign dmem_resp       = resp_q;
    assign dmem_rdata      = rdata_q;
    assign mem_ack_counter = cnt_q;

endmodule

// File: tb/tb_dmem_wb_master.sv
// Scoreboard bench for dmem_wb_master: a word-array memory model predicts bus fields,
// read data, response cycle and access count; monitors compare when the DUT presents them.
module tb_dmem_wb_master;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmem_action_cyc, dmem_action_stb, dmem_write, load_ex_mem;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] dmem_address, dmem_wdata;
    logic        dmem_resp, dmem_err;
    logic [15:0] dmem_rdata;
    logic [1:0]  mem_ack_counter;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [1:0]  wb_sel_o;
    logic [14:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [15:0] wb_dat_i;
    logic        wb_ack_i;

    always #5 clk = ~clk;

    dmem_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .dmem_action_cyc(dmem_action_cyc), .dmem_action_stb(dmem_action_stb),
        .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .load_ex_mem(load_ex_mem), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .mem_ack_counter(mem_ack_counter), .dmem_err(dmem_err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    typedef struct {
        logic        we;
        logic [1:0]  sel;
        logic [14:0] adr;
        logic [15:0] dat;
    } bus_t;

    typedef struct {
        logic [15:0] rdata;
        logic [1:0]  cnt;
        int          cycle;
    } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    int    checks = 0;
    int    fails = 0;
    int    cycle = 0;
    int    resp_seen = 0;

    bit [15:0]   ref_mem [32768];
    bit [15:0]   slv_mem [32768];
    logic [15:0] last_rdata = 16'h0000;
    int          cnt_model = 0;

    int slv_wait = 0;
    int slv_cnt = 0;
    bit slv_hang = 1'b0;
    bit noise_en = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Wishbone slave with programmable wait states and random ack noise outside cycles.
    always @(negedge clk) begin
        if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1) begin
            if (!slv_hang && slv_cnt == slv_wait) begin
                wb_ack_i = 1'b1;
                wb_dat_i = slv_mem[wb_adr_o];
                if (wb_we_o) begin
                    if (wb_sel_o[0]) slv_mem[wb_adr_o][7:0]  = wb_dat_o[7:0];
                    if (wb_sel_o[1]) slv_mem[wb_adr_o][15:8] = wb_dat_o[15:8];
                end
            end else begin
                wb_ack_i = 1'b0;
                wb_dat_i = 16'($urandom);
            end
            slv_cnt++;
        end else begin
            slv_cnt  = 0;
            wb_ack_i = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
            wb_dat_i = 16'($urandom);
        end
    end

    bit   prev_cyc = 1'b0;
    bus_t cur_bus;

    always @(negedge clk) begin
        if (wb_cyc_o === 1'b1 && !prev_cyc) begin
            if (bus_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_bus_cycle: got adr %0h, expected none", wb_adr_o);
            end else begin
                cur_bus = bus_q.pop_front();
                check("wb_stb", 32'(wb_stb_o), 32'd1);
                check("wb_adr", 32'(wb_adr_o), 32'(cur_bus.adr));
                check("wb_we", 32'(wb_we_o), 32'(cur_bus.we));
                check("wb_sel", 32'(wb_sel_o), 32'(cur_bus.sel));
                if (cur_bus.we) check("wb_dat", 32'(wb_dat_o), 32'(cur_bus.dat));
            end
        end else if (wb_cyc_o === 1'b1) begin
            check("wb_hold", 32'({wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o}),
                  32'({1'b1, cur_bus.we, cur_bus.sel, cur_bus.adr}));
        end
        prev_cyc = (wb_cyc_o === 1'b1);
    end

    bit          prev_resp = 1'b0;
    bit          cnt_chk = 1'b0;
    logic [1:0]  cnt_exp;
    resp_t       cur_resp;

    always @(negedge clk) begin
        if (dmem_resp === 1'b1) begin
            resp_seen++;
            if (prev_resp) begin
                checks++;
                fails++;
                $display("FAIL resp_width: got 2+ cycles, expected 1");
            end else if (resp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_resp: got resp, expected none (cycle %0d)", cycle);
            end else begin
                cur_resp = resp_q.pop_front();
                check("resp_rdata", 32'(dmem_rdata), 32'(cur_resp.rdata));
                check("resp_cycle", 32'(cycle), 32'(cur_resp.cycle));
                cnt_exp = cur_resp.cnt;
                cnt_chk = 1'b1;
            end
        end else if (cnt_chk) begin
            check("ack_counter", 32'(mem_ack_counter), 32'(cnt_exp));
            check("rdata_held", 32'(dmem_rdata), 32'(cur_resp.rdata));
            cnt_chk = 1'b0;
        end
        prev_resp = (dmem_resp === 1'b1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dmem_action_cyc = 1'b0;
        dmem_action_stb = 1'b0;
        load_ex_mem     = 1'b0;
    endtask

    // Drive a request while the DUT is idle and record its expected outcome.
    task automatic issue(input logic we, input logic [1:0] be, input logic [15:0] addr,
                         input logic [15:0] wd, input int waits, input bit new_instr,
                         input bit clr_at_resp);
        bus_t        b;
        resp_t       r;
        logic [15:0] w;
        slv_wait         = waits;
        load_ex_mem      = new_instr;
        dmem_action_cyc  = 1'b1;
        dmem_action_stb  = 1'b1;
        dmem_write       = we;
        dmem_byte_enable = be;
        dmem_address     = addr;
        dmem_wdata       = wd;
        b.we  = we;
        b.sel = we ? be : 2'b11;
        b.adr = addr[15:1];
        b.dat = (be == 2'b11) ? wd : {wd[7:0], wd[7:0]};
        bus_q.push_back(b);
        if (we) begin
            w = ref_mem[addr[15:1]];
            if (be[0]) w[7:0]  = wd[7:0];
            if (be[1]) w[15:8] = (be == 2'b11) ? wd[15:8] : wd[7:0];
            ref_mem[addr[15:1]] = w;
        end else begin
            last_rdata = ref_mem[addr[15:1]];
        end
        if (new_instr) cnt_model = 0;
        cnt_model = (cnt_model >= 3) ? 3 : cnt_model + 1;
        if (clr_at_resp) cnt_model = 0;
        r.rdata = last_rdata;
        r.cnt   = 2'(cnt_model);
        r.cycle = cycle + 2 + waits;
        resp_q.push_back(r);
    endtask

    task automatic wait_resp(input int target);
        int budget = 64;
        while (resp_seen < target && budget > 0) begin
            tick();
            budget--;
        end
        if (resp_seen < target) begin
            checks++;
            fails++;
            $display("FAIL resp_timeout: got %0d responses, expected %0d", resp_seen, target);
        end
    endtask

    task automatic access(input logic we, input logic [1:0] be, input logic [15:0] addr,
                          input logic [15:0] wd, input int waits, input bit new_instr,
                          input bit clr_at_resp);
        int tgt = resp_seen + 1;
        issue(we, be, addr, wd, waits, new_instr, clr_at_resp);
        tick();
        idle_inputs();
        wait_resp(tgt);
        if (clr_at_resp) load_ex_mem = 1'b1;
        tick();
        load_ex_mem = 1'b0;
    endtask

    initial begin
        int         tgt;
        logic [1:0] be;
        bus_t       b;
        rst_n            = 1'b0;
        idle_inputs();
        dmem_write       = 1'b0;
        dmem_byte_enable = 2'b11;
        dmem_address     = '0;
        dmem_wdata       = '0;
        ref_mem[15'h091A] = 16'hBEEF;  slv_mem[15'h091A] = 16'hBEEF;
        ref_mem[15'h1800] = 16'h1357;  slv_mem[15'h1800] = 16'h1357;
        ref_mem[15'h2000] = 16'h2468;  slv_mem[15'h2000] = 16'h2468;
        tick();
        tick();
        check("reset_outputs", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, dmem_resp}), 32'd0);
        check("reset_wdat", 32'(wb_dat_o), 32'd0);
        check("reset_state", 32'({dmem_rdata, mem_ack_counter, dmem_err}), 32'd0);
        rst_n = 1'b1;

        // Word load with two wait states, then a high-byte store.
        access(1'b0, 2'b11, 16'h1234, 16'h0000, 2, 1'b1, 1'b0);
        access(1'b1, 2'b10, 16'h2001, 16'h00A5, 0, 1'b0, 1'b0);

        // Indirect load: request held high, address switched after the first response.
        tgt = resp_seen + 1;
        issue(1'b0, 2'b11, 16'h3000, 16'h0000, 0, 1'b1, 1'b0);
        tick();
        load_ex_mem = 1'b0;
        wait_resp(tgt);
        dmem_address = 16'h4000;
        tick();
        tgt = resp_seen + 1;
        issue(1'b0, 2'b11, 16'h4000, 16'h0000, 0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        wait_resp(tgt);
        tick();

        // New instruction arriving in the completion cycle.
        access(1'b0, 2'b11, 16'h3000, 16'h0000, 1, 1'b0, 1'b1);

        // Reset while the slave is stalling: cycle dies with no response.
        slv_wait         = 20;
        dmem_action_cyc  = 1'b1;
        dmem_action_stb  = 1'b1;
        dmem_write       = 1'b0;
        dmem_byte_enable = 2'b11;
        dmem_address     = 16'h0F00;
        b.we = 1'b0; b.sel = 2'b11; b.adr = 15'h0780; b.dat = '0;
        bus_q.push_back(b);
        tick();
        idle_inputs();
        check("bus_active_before_reset", 32'(wb_cyc_o), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_bus_reset_bus", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, dmem_resp}), 32'd0);
        check("mid_bus_reset_state", 32'({dmem_rdata, mem_ack_counter, dmem_err}), 32'd0);
        rst_n      = 1'b1;
        last_rdata = 16'h0000;
        cnt_model  = 0;
        repeat (4) tick();

        // Randomised traffic over a small address window with ack noise.
        noise_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       be = 2'b11;
                1:       be = 2'b01;
                default: be = 2'b10;
            endcase
            access(1'($urandom_range(0, 1)), be, 16'h5000 | 16'($urandom_range(0, 63)),
                   16'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1'b0);
        end
        noise_en = 1'b0;

`ifdef DMEM_TIMEOUT_EN
        slv_hang = 1'b1;
        access(1'b0, 2'b11, 16'h7000, 16'h0000, TO - 1, 1'b1, 1'b0);
        slv_hang = 1'b0;
        check("timeout_err", 32'(dmem_err), 32'd1);
        access(1'b0, 2'b11, 16'h1234, 16'h0000, 0, 1'b0, 1'b0);
        check("timeout_err_sticky", 32'(dmem_err), 32'd1);
`else
        check("err_tied_low", 32'(dmem_err), 32'd0);
`endif

        repeat (4) tick();
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        check("resp_queue_drained", 32'(resp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
